// File: rtl/instruction_stream_generator_pkg.sv
// Shared types and constants for the BIST instruction stream generator.
// Holds the core feature-flag struct, generator classes, LFSR constants and RV32 opcodes.
package instruction_stream_generator_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned COUNT_W = 16;

    typedef struct packed {
        logic INCLUDE_MUL;
        logic INCLUDE_DIV;
        logic INCLUDE_AMO;
        logic INCLUDE_CSRS;
    } cpu_config_t;

    localparam cpu_config_t EXAMPLE_CONFIG = '{
        INCLUDE_MUL:  1'b1,
        INCLUDE_DIV:  1'b1,
        INCLUDE_AMO:  1'b1,
        INCLUDE_CSRS: 1'b1
    };

    typedef enum logic [3:0] {
        GEN_OP0, GEN_OP1, GEN_OP2, GEN_OP3, GEN_OP4, GEN_OP5,
        GEN_OP_IMM0, GEN_OP_IMM1,
        GEN_LOAD, GEN_STORE, GEN_BRANCH,
        GEN_MUL, GEN_DIV, GEN_AMO, GEN_CSR, GEN_ILLEGAL
    } gen_class_t;

    localparam logic [XLEN-1:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [XLEN-1:0] DEFAULT_SEED = 32'hACE1_2345;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_AMO     = 7'b0101111;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_ILLEGAL = 7'b1111111;

    localparam logic [6:0]  FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;

    // Right-shifting Galois step
    function automatic logic [XLEN-1:0] lfsr_step(input logic [XLEN-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/instruction_field_encoder.sv
// Builds one RV32 instruction word from an LFSR state, honouring the core feature flags.
// Purely combinational; classes the configuration lacks fall back to a plain OP encoding.
module instruction_field_encoder
    import instruction_stream_generator_pkg::*;
#(
    parameter cpu_config_t CONFIG         = EXAMPLE_CONFIG,
    parameter logic        ILLEGAL_ENABLE = 1'b1
) (
    input  logic [31:0] r,
    output logic [31:0] instruction,
    output logic        expected_illegal
);

    gen_class_t cls_raw;
    gen_class_t cls;
    logic [6:0] upper;
    logic [4:0] rs2_f;
    logic [4:0] rs1_f;
    logic [2:0] f3;
    logic [4:0] rd_f;
    logic [6:0] opcode;

    // r[6:4] never reach the word
    logic unused_bits;
    assign unused_bits = ^r[6:4];

    always_comb begin
        cls_raw = gen_class_t'(r[3:0]);
        cls     = cls_raw;
        case (cls_raw)
            GEN_MUL:     if (!CONFIG.INCLUDE_MUL)  cls = GEN_OP0;
            GEN_DIV:     if (!CONFIG.INCLUDE_DIV)  cls = GEN_OP0;
            GEN_AMO:     if (!CONFIG.INCLUDE_AMO)  cls = GEN_OP0;
            GEN_CSR:     if (!CONFIG.INCLUDE_CSRS) cls = GEN_OP0;
            GEN_ILLEGAL: if (!ILLEGAL_ENABLE)      cls = GEN_OP0;
            default:     cls = cls_raw;
        endcase
    end

    always_comb begin
        upper            = r[31:25];
        rs2_f            = r[24:20];
        rs1_f            = r[19:15];
        f3               = r[14:12];
        rd_f             = r[11:7];
        opcode           = OPC_OP;
        expected_illegal = 1'b0;
        case (cls)
            GEN_OP0, GEN_OP1, GEN_OP2, GEN_OP3, GEN_OP4, GEN_OP5: begin
                // SUB/SRA only exist for funct3 000/101
                upper = (r[30] && (f3 == 3'b000 || f3 == 3'b101)) ? FUNCT7_ALT : 7'b0;
            end
            GEN_OP_IMM0, GEN_OP_IMM1: begin
                opcode = OPC_OP_IMM;
                if (f3 == 3'b001)      upper = 7'b0;
                else if (f3 == 3'b101) upper = {1'b0, r[30], 5'b0};
            end
            GEN_LOAD: begin
                opcode = OPC_LOAD;
                if (f3 == 3'b011 || f3[2:1] == 2'b11) f3 = 3'b010;
            end
            GEN_STORE: begin
                opcode = OPC_STORE;
                if (r[14] || (&r[13:12])) f3 = 3'b010;
            end
            GEN_BRANCH: begin
                opcode = OPC_BRANCH;
                if (f3[2:1] == 2'b01) f3 = 3'b000;
            end
            GEN_MUL: begin
                upper = FUNCT7_MULDIV;
                f3    = {1'b0, r[13:12]};
            end
            GEN_DIV: begin
                upper = FUNCT7_MULDIV;
                f3    = {1'b1, r[13:12]};
            end
            GEN_AMO: begin
                // AMOADD.W, aq/rl left random
                opcode = OPC_AMO;
                upper  = {5'b00000, r[26:25]};
                f3     = 3'b010;
            end
            GEN_CSR: begin
                opcode = OPC_SYSTEM;
                upper  = CSR_CYCLE[11:5];
                rs2_f  = CSR_CYCLE[4:0];
                rs1_f  = 5'b0;
                f3     = 3'b010;
            end
            GEN_ILLEGAL: begin
                opcode           = OPC_ILLEGAL;
                expected_illegal = 1'b1;
            end
            default: opcode = OPC_OP;
        endcase
        instruction = {upper, rs2_f, rs1_f, f3, rd_f, opcode};
    end

endmodule

// File: rtl/instruction_stream_generator.sv
// BIST source streaming pseudo-random RV32 words over valid/ready, each tagged legal or illegal.
// Holds the run FSM, the LFSR, the remaining-word counter and the registered outputs.
module instruction_stream_generator
    import instruction_stream_generator_pkg::*;
#(
    parameter cpu_config_t CONFIG         = EXAMPLE_CONFIG,
    parameter logic [31:0] SEED           = DEFAULT_SEED,
    parameter logic        ILLEGAL_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] count,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic        expected_illegal,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [XLEN-1:0]    lfsr;
    logic [XLEN-1:0]    lfsr_next;
    logic [COUNT_W-1:0] remaining;
    logic [COUNT_W-1:0] remaining_next;
    logic               valid_next;
    logic [31:0]        instruction_next;
    logic               illegal_next;
    logic               busy_next;
    logic               done_next;
    logic [31:0]        enc_instruction;
    logic               enc_illegal;

    instruction_field_encoder #(
        .CONFIG         (CONFIG),
        .ILLEGAL_ENABLE (ILLEGAL_ENABLE)
    ) u_encoder (
        .r                (lfsr),
        .instruction      (enc_instruction),
        .expected_illegal (enc_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            lfsr             <= SEED;
            remaining        <= '0;
            inst_valid       <= 1'b0;
            instruction      <= '0;
            expected_illegal <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            state            <= state_next;
            lfsr             <= lfsr_next;
            remaining        <= remaining_next;
            inst_valid       <= valid_next;
            instruction      <= instruction_next;
            expected_illegal <= illegal_next;
            busy             <= busy_next;
            done             <= done_next;
        end
    end

    // Every loaded word consumes exactly one LFSR step
    always_comb begin
        state_next       = state;
        lfsr_next        = lfsr;
        remaining_next   = remaining;
        valid_next       = inst_valid;
        instruction_next = instruction;
        illegal_next     = expected_illegal;
        busy_next        = busy;
        done_next        = done;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (count != '0) begin
                        state_next       = RUN;
                        remaining_next   = count;
                        instruction_next = enc_instruction;
                        illegal_next     = enc_illegal;
                        lfsr_next        = lfsr_step(lfsr);
                        valid_next       = 1'b1;
                        busy_next        = 1'b1;
                        done_next        = 1'b0;
                    end else begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (inst_valid && inst_ready) begin
                    if (remaining == COUNT_W'(1)) begin
                        state_next     = DONE;
                        remaining_next = '0;
                        valid_next     = 1'b0;
                        busy_next      = 1'b0;
                        done_next      = 1'b1;
                    end else begin
                        remaining_next   = remaining - COUNT_W'(1);
                        instruction_next = enc_instruction;
                        illegal_next     = enc_illegal;
                        lfsr_next        = lfsr_step(lfsr);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instruction_stream_generator.sv
// Randomised self-checking bench: a transaction-level model predicts every word and handshake
// state for a full-feature and a feature-gated generator driven by the same stimulus.
module tb_instruction_stream_generator;
    import instruction_stream_generator_pkg::*;

    localparam cpu_config_t FULL_CFG  = '{INCLUDE_MUL: 1'b1, INCLUDE_DIV: 1'b1,
                                          INCLUDE_AMO: 1'b1, INCLUDE_CSRS: 1'b1};
    localparam cpu_config_t GATED_CFG = '{INCLUDE_MUL: 1'b0, INCLUDE_DIV: 1'b0,
                                          INCLUDE_AMO: 1'b0, INCLUDE_CSRS: 1'b1};

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] count;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] instruction;
    logic        expected_illegal;
    logic        busy;
    logic        done;
    logic        g_valid;
    logic [31:0] g_instruction;
    logic        g_illegal;
    logic        g_busy;
    logic        g_done;

    int n_checks = 0;
    int n_pass   = 0;

    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_r = DEFAULT_SEED;
    int          dut_xfers = 0;
    logic [31:0] run_words[$];
    logic        prev_hold = 1'b0;
    logic [31:0] prev_word = '0;
    int          ready_pct = 100;
    logic        hold_low = 1'b0;

    instruction_stream_generator #(
        .CONFIG(FULL_CFG), .SEED(DEFAULT_SEED), .ILLEGAL_ENABLE(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .count(count),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction),
        .expected_illegal(expected_illegal), .busy(busy), .done(done)
    );

    instruction_stream_generator #(
        .CONFIG(GATED_CFG), .SEED(DEFAULT_SEED), .ILLEGAL_ENABLE(1'b0)
    ) dut_gated (
        .clk(clk), .rst(rst), .start(start), .count(count),
        .inst_valid(g_valid), .inst_ready(inst_ready), .instruction(g_instruction),
        .expected_illegal(g_illegal), .busy(g_busy), .done(g_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    function automatic logic [31:0] model_step(input logic [31:0] s);
        logic [31:0] t;
        t = {1'b0, s[31:1]};
        if (s[0]) t = t ^ 32'h8020_0003;
        return t;
    endfunction

    // Expected {illegal, word} straight from the class table
    function automatic logic [32:0] gold(input logic [31:0] r, input cpu_config_t cfg, input logic ill_en);
        int          cls;
        logic [2:0]  f3;
        logic [6:0]  hi;
        logic [32:0] res;
        cls = int'(r[3:0]);
        f3  = r[14:12];
        if ((cls == 11 && !cfg.INCLUDE_MUL) || (cls == 12 && !cfg.INCLUDE_DIV) ||
            (cls == 13 && !cfg.INCLUDE_AMO) || (cls == 14 && !cfg.INCLUDE_CSRS) ||
            (cls == 15 && !ill_en)) cls = 0;
        case (cls)
            6, 7: begin
                hi = r[31:25];
                if (f3 == 3'd1) hi = 7'd0;
                if (f3 == 3'd5) hi = {1'b0, r[30], 5'd0};
                res = {1'b0, hi, r[24:15], f3, r[11:7], 7'h13};
            end
            8: begin
                if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) f3 = 3'd2;
                res = {1'b0, r[31:15], f3, r[11:7], 7'h03};
            end
            9: begin
                if (f3 > 3'd2) f3 = 3'd2;
                res = {1'b0, r[31:15], f3, r[11:7], 7'h23};
            end
            10: begin
                if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd0;
                res = {1'b0, r[31:15], f3, r[11:7], 7'h63};
            end
            11: res = {1'b0, 7'h01, r[24:15], 1'b0, r[13:12], r[11:7], 7'h33};
            12: res = {1'b0, 7'h01, r[24:15], 1'b1, r[13:12], r[11:7], 7'h33};
            13: res = {1'b0, 5'd0, r[26:25], r[24:15], 3'd2, r[11:7], 7'h2F};
            14: res = {1'b0, 12'hC00, 5'd0, 3'd2, r[11:7], 7'h73};
            15: res = {1'b1, r[31:7], 7'h7F};
            default: begin
                hi  = (r[30] && (f3 == 3'd0 || f3 == 3'd5)) ? 7'h20 : 7'h00;
                res = {1'b0, hi, r[24:15], f3, r[11:7], 7'h33};
            end
        endcase
        return res;
    endfunction

    // Independent decode-side legality check of a finished word
    function automatic logic dec_illegal(input logic [31:0] w, input cpu_config_t cfg);
        logic [6:0] f7;
        logic [2:0] f3;
        logic [4:0] f5;
        logic       ill;
        f7  = w[31:25];
        f3  = w[14:12];
        f5  = w[31:27];
        ill = 1'b1;
        case (w[6:0])
            7'h33: begin
                if (f7 == 7'h00) ill = 1'b0;
                else if (f7 == 7'h20) ill = !(f3 == 3'd0 || f3 == 3'd5);
                else if (f7 == 7'h01) ill = f3[2] ? !cfg.INCLUDE_DIV : !cfg.INCLUDE_MUL;
            end
            7'h13: begin
                if (f3 == 3'd1) ill = (f7 != 7'h00);
                else if (f3 == 3'd5) ill = !(f7 == 7'h00 || f7 == 7'h20);
                else ill = 1'b0;
            end
            7'h03: ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
            7'h23: ill = (f3 > 3'd2);
            7'h63: ill = (f3 == 3'd2 || f3 == 3'd3);
            7'h2F: ill = !(cfg.INCLUDE_AMO && f3 == 3'd2 &&
                           (f5 inside {5'h00, 5'h01, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C}));
            7'h73: ill = !(cfg.INCLUDE_CSRS && f3 == 3'd2);
            default: ill = 1'b1;
        endcase
        return ill;
    endfunction

    initial begin
        inst_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            inst_ready = hold_low ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Compare outputs, then advance the model for the coming edge
    always @(negedge clk) begin
        logic [32:0] ef;
        logic [32:0] eg;
        if (rst) begin
            m_left    = 0;
            m_done    = 1'b0;
            m_r       = DEFAULT_SEED;
            prev_hold = 1'b0;
        end else begin
            chk("valid", 32'(inst_valid), 32'(m_left != 0));
            chk("busy", 32'(busy), 32'(m_left != 0));
            chk("done", 32'(done), 32'(m_done));
            chk("g_valid", 32'(g_valid), 32'(m_left != 0));
            chk("g_busy", 32'(g_busy), 32'(m_left != 0));
            chk("g_done", 32'(g_done), 32'(m_done));
            if (m_left != 0) begin
                ef = gold(m_r, FULL_CFG, 1'b1);
                eg = gold(m_r, GATED_CFG, 1'b0);
                chk("word", instruction, ef[31:0]);
                chk("illegal", 32'(expected_illegal), 32'(ef[32]));
                chk("decode_xcheck", 32'(dec_illegal(instruction, FULL_CFG)), 32'(expected_illegal));
                chk("g_word", g_instruction, eg[31:0]);
                chk("g_illegal_never", 32'(g_illegal), 32'd0);
                chk("g_no_muldiv", 32'(g_instruction[6:0] == 7'h33 && g_instruction[31:25] == 7'h01), 32'd0);
                chk("g_no_amo", 32'(g_instruction[6:0] == 7'h2F), 32'd0);
                chk("g_decode_xcheck", 32'(dec_illegal(g_instruction, GATED_CFG)), 32'd0);
                if (prev_hold) chk("hold_stable", instruction, prev_word);
            end
            prev_hold = inst_valid && !inst_ready;
            prev_word = instruction;
            if (inst_valid && inst_ready) begin
                dut_xfers++;
                run_words.push_back(instruction);
            end
            if (m_left == 0) begin
                if (start) begin
                    m_left    = int'(count);
                    m_done    = (count == 16'd0);
                    dut_xfers = 0;
                    run_words.delete();
                end
            end else if (inst_ready) begin
                m_r = model_step(m_r);
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end
        end
    end

    task automatic start_run(input logic [15:0] c);
        @(posedge clk);
        #1;
        start = 1'b1;
        count = c;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_xfers);
        int n;
        n = 0;
        while (m_left != 0 && n < exp_xfers * 20 + 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("run_timeout", 32'(m_left != 0), 32'd0);
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_valid", 32'(inst_valid), 32'd0);
        chk("xfer_count", 32'(dut_xfers), 32'(exp_xfers));
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(inst_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_word", instruction, 32'd0);
        chk("arst_illegal", 32'(expected_illegal), 32'd0);
        chk("arst_g_valid", 32'(g_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] ref_q[$];
        logic [32:0] lit;
        logic [31:0] r_saved;
        int          n;
        rst   = 1'b1;
        start = 1'b0;
        count = '0;
        #2;
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_word", instruction, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // slt x6,x2,x14 from SEED, then sll x3,x1,x5 from the next state
        lit = gold(DEFAULT_SEED, FULL_CFG, 1'b1);
        chk("model_lit0", lit[31:0], 32'h00E1_2333);

        ready_pct = 70;
        start_run(16'd100);
        wait_done(100);
        ref_q = run_words;
        chk("ref_len", 32'(ref_q.size()), 32'd100);
        if (ref_q.size() >= 2) begin
            chk("first_word_lit", ref_q[0], 32'h00E1_2333);
            chk("second_word_lit", ref_q[1], 32'h0050_91B3);
        end

        // Reset at word 10, then the restarted stream must replay the fresh-reset one
        ready_pct = 100;
        start_run(16'd100);
        n = 0;
        while (dut_xfers < 10 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mid_wait_timeout", 32'(dut_xfers >= 10), 32'd1);
        reset_mid();
        ready_pct = 50;
        start_run(16'd100);
        wait_done(100);
        chk("replay_len", 32'(run_words.size()), 32'(ref_q.size()));
        if (run_words.size() == ref_q.size())
            foreach (ref_q[i]) chk("replay_word", run_words[i], ref_q[i]);

        // count=0 finishes at once and leaves the LFSR alone
        r_saved = m_r;
        start_run(16'd0);
        wait_done(0);

        // Backpressure: ready held low for five cycles after the first valid
        hold_low  = 1'b1;
        ready_pct = 100;
        start_run(16'd4);
        repeat (5) @(posedge clk);
        hold_low = 1'b0;
        wait_done(4);
        lit = gold(r_saved, FULL_CFG, 1'b1);
        if (run_words.size() > 0) chk("after_zero_first", run_words[0], lit[31:0]);

        // start during RUN must be ignored
        ready_pct = 60;
        start_run(16'd20);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        count = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(20);

        ready_pct = 60;
        start_run(16'd4096);
        wait_done(4096);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_stream_generator.md
# instruction_stream_generator

Self-test source that emits a pseudo-random stream of encoded RV32 instructions over a valid/ready handshake, with each word tagged by whether it must be rejected as illegal. It is the encoding counterpart of the decode-side illegal-instruction check. It sits in the BIST/debug path, feeding either fetch or the illegal-instruction checker directly. The instruction mix follows the same CONFIG feature flags as the core, so every word tagged legal is legal for that configuration.

## Interface
Parameters:
- CONFIG: EXAMPLE_CONFIG. cpu_config_t; only INCLUDE_MUL, INCLUDE_DIV, INCLUDE_AMO and INCLUDE_CSRS are used.
- SEED: 32'hACE1_2345. LFSR reset value; must be nonzero.
- ILLEGAL_ENABLE: 1. When 1, the generator may emit deliberately illegal words.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; asynchronous, active-high.
- start, input, 1, run request; sampled only in IDLE or DONE.
- count, input, 16, number of instructions in the run; sampled with start.
- inst_valid, output, 1, instruction word valid.
- inst_ready, input, 1, consumer accepts the word.
- instruction, output, 32, encoded word.
- expected_illegal, output, 1, the word must be flagged illegal.
- busy, output, 1, high in RUN.
- done, output, 1, high in DONE until the next start.

## Operation
- FSM states:
  - IDLE: start with count≠0 goes to RUN; start with count=0 goes to DONE.
  - RUN: the final handshake goes to DONE.
  - DONE: start re-enters as from IDLE.
- LFSR: 32-bit Galois, taps 32'h8020_0003, shifted right. It advances exactly once per word loaded. r denotes the state used to build a word.
- Word build from r:
  - Class selected by r[3:0].
  - rd=r[11:7], rs1=r[19:15], rs2=r[24:20], imm=r[31:20].
- Class map:
  - 0–5: OP. funct3=r[14:12]. funct7=0, except funct7=0100000 when r[30]=1 and funct3 ∈ {000,101}.
  - 6–7: OP-IMM. For funct3 001/101, bits [31:25]=0, except bit 30=r[30] when funct3=101.
  - 8: LOAD. funct3 011/110/111 is forced to 010.
  - 9: STORE. r[14]=1 or r[13:12]=11 forces funct3 to 010.
  - 10: BRANCH. funct3 010/011 is forced to 000.
  - 11: MUL group (funct7=0000001, funct3=0,r[13:12]).
  - 12: DIV group (funct7=0000001, funct3=1,r[13:12]).
  - 13: AMO_ADD.W (funct5=00000, funct3=010).
  - 14: CSRRS from CYCLE (12'hC00) with rs1=0.
  - 15: illegal. Opcode=7'b1111111, upper bits from r, expected_illegal=1.
- Feature gating: any class disabled by CONFIG or ILLEGAL_ENABLE is re-encoded as ADD (class 0 rules) with expected_illegal=0.
- expected_illegal is 1 only for an emitted class 15 word.

## Timing
- Reset values: state IDLE, LFSR=SEED, inst_valid=0, instruction=0, expected_illegal=0, busy=0, done=0, remaining count=0.
- Start latency: start accepted at edge N means the first word, inst_valid=1 and busy=1 are registered at N.
- Handshake:
  - A word transfers on an edge with inst_valid & inst_ready.
  - instruction and expected_illegal hold stable while inst_valid=1 and inst_ready=0.
  - Throughput is back-to-back, 1 word/cycle. The next word is loaded on the same edge as the accepting handshake.
- Final handshake (remaining=1): inst_valid=0, busy=0 and done=1 registered on that edge. No extra LFSR step.
- count=0: done=1 is registered on the start edge; inst_valid is never asserted.
- start during RUN is ignored; count is not re-sampled.
- rst mid-run returns all state to reset values immediately (asynchronously), including the LFSR.
- remaining is a 16-bit down-counter; count=16'hFFFF produces 65535 words with no wrap.

## Structure
- Shared package (cva5_config, or a new BIST package) holds:
  - gen_class_t enum for the 16 classes.
  - LFSR tap constant and default SEED.
  - Opcode values, taken from riscv_types.
- Sub-module instruction_field_encoder, purely combinational:
  - Input: r and CONFIG.
  - Output: instruction and expected_illegal.
- Top level holds the FSM, LFSR, counter and output registers.

## Test plan
- Reset check: assert rst mid-cycle → inst_valid=0, done=0, busy=0 without waiting for a clock edge. Deassert, start with count=3 → first word matches the golden encoder applied to SEED.
- count=0: start → done=1 one edge later, inst_valid stays 0, LFSR unchanged.
- Backpressure: count=4, inst_ready low for 5 cycles after the first valid → instruction stable across those cycles. Exactly 4 transfers occur, then done=1.
- Cross-check: count=4096, inst_ready=1, output fed into illegal_instruction_checker with the full EXAMPLE_CONFIG → its illegal_instruction equals expected_illegal on every word, 0 mismatches.
- Gating: INCLUDE_MUL=0, INCLUDE_DIV=0, INCLUDE_AMO=0, ILLEGAL_ENABLE=0, count=4096 → no word has opcode 0110011 with funct7 0000001, no opcode 0101111, and expected_illegal is never 1.
- Reset mid-run: rst at word 10 of count=100, then restart with count=100 → the stream is identical to a run from a fresh reset.
